// File: rtl/cpx_mult_axis.sv
`default_nettype none
// ============================================================================
// Module  : cpx_mult_axis
// Brief   : 3-stage pipelined complex multiplier (x*y or x*conj(y)) with
//           valid/ready handshakes. Define CPX_MULT_SAT_EN to saturate the
//           output instead of two's-complement wrap.
// Rev     : 1.0  initial release
// ============================================================================

module cpx_mult_axis #(
  parameter int XB       = 12,
  parameter int YB       = 12,
  parameter int OUT_BITS = 16,
  parameter int SHIFT    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m_axis_x_tvalid,
  output logic                m_axis_x_tready,
  input  logic [XB-1:0]       xi,
  input  logic [XB-1:0]       xq,
  input  logic                m_axis_y_tvalid,
  output logic                m_axis_y_tready,
  input  logic [YB-1:0]       yi,
  input  logic [YB-1:0]       yq,
  input  logic                conj,
  input  logic                last_in,
  output logic                s_axis_tvalid,
  input  logic                s_axis_tready,
  output logic [OUT_BITS-1:0] i,
  output logic [OUT_BITS-1:0] q,
  output logic                s_axis_tlast
);

  localparam int P  = XB + YB + 1;
  localparam int RW = P + 1;

  logic                w_adv;
  logic                w_fire;
  logic                vld1_q, vld2_q, vld3_q;
  logic                cnj1_q;
  logic                lst1_q, lst2_q, lst3_q;
  logic signed [P-1:0] w_xi, w_xq, w_yi, w_yq;
  logic signed [P-1:0] pii_d, pqq_d, pqi_d, piq_d;
  logic signed [P-1:0] pii_q, pqq_q, pqi_q, piq_q;
  logic signed [P-1:0] si_d, sq_d, si_q, sq_q;
  logic [OUT_BITS-1:0] i_q, q_q;
  logic signed [P-1:0] w_s [2];
  logic [OUT_BITS-1:0] w_o [2];

  // The whole pipeline advances as one unit whenever the output slot can move.
  assign w_adv           = !vld3_q || s_axis_tready;
  assign w_fire          = m_axis_x_tvalid && m_axis_y_tvalid && w_adv;
  assign m_axis_x_tready = !rst && w_adv && m_axis_y_tvalid;
  assign m_axis_y_tready = !rst && w_adv && m_axis_x_tvalid;

  assign w_xi = {{(P-XB){xi[XB-1]}}, xi};
  assign w_xq = {{(P-XB){xq[XB-1]}}, xq};
  assign w_yi = {{(P-YB){yi[YB-1]}}, yi};
  assign w_yq = {{(P-YB){yq[YB-1]}}, yq};

  always_comb begin
    pii_d = w_xi * w_yi;
    pqq_d = w_xq * w_yq;
    pqi_d = w_xq * w_yi;
    piq_d = w_xi * w_yq;
    si_d  = cnj1_q ? (pii_q + pqq_q) : (pii_q - pqq_q);
    sq_d  = cnj1_q ? (pqi_q - piq_q) : (pqi_q + piq_q);
  end

  assign w_s[0] = si_q;
  assign w_s[1] = sq_q;

  for (genvar c = 0; c < 2; c++) begin : g_comp
    logic signed [RW-1:0] w_v;
    logic signed [RW-1:0] w_r;
    assign w_v = {w_s[c][P-1], w_s[c]};

    if (SHIFT > 0) begin : g_rnd
      localparam logic signed [RW-1:0] C_HALF = RW'(1) << (SHIFT - 1);
      logic signed [RW-1:0] w_sum;
      assign w_sum = w_v + C_HALF;
      assign w_r   = w_sum >>> SHIFT;
    end else begin : g_nornd
      assign w_r = w_v;
    end

    if (OUT_BITS >= RW) begin : g_ext
      assign w_o[c] = OUT_BITS'(w_r);
    end else begin : g_red
`ifdef CPX_MULT_SAT_EN
      // Overflow when the bits above the output sign bit disagree with it.
      logic w_ovf;
      assign w_ovf  = !((&w_r[RW-1:OUT_BITS-1]) || !(|w_r[RW-1:OUT_BITS-1]));
      assign w_o[c] = w_ovf ? {w_r[RW-1], {(OUT_BITS-1){!w_r[RW-1]}}}
                            : w_r[OUT_BITS-1:0];
`else
      assign w_o[c] = w_r[OUT_BITS-1:0];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld1_q <= 1'b0;
      vld2_q <= 1'b0;
      vld3_q <= 1'b0;
      lst3_q <= 1'b0;
      i_q    <= '0;
      q_q    <= '0;
    end else if (w_adv) begin
      vld1_q <= w_fire;
      vld2_q <= vld1_q;
      vld3_q <= vld2_q;
      lst3_q <= lst2_q;
      i_q    <= w_o[0];
      q_q    <= w_o[1];
    end
  end

  always_ff @(posedge clk) begin
    if (w_adv) begin
      cnj1_q <= conj;
      lst1_q <= last_in;
      pii_q  <= pii_d;
      pqq_q  <= pqq_d;
      pqi_q  <= pqi_d;
      piq_q  <= piq_d;
      lst2_q <= lst1_q;
      si_q   <= si_d;
      sq_q   <= sq_d;
    end
  end

  assign s_axis_tvalid = vld3_q;
  assign s_axis_tlast  = lst3_q;
  assign i             = i_q;
  assign q             = q_q;

endmodule

`default_nettype wire

// File: tb/tb_cpx_mult_axis.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpx_mult_axis
// Brief   : Self-checking bench for cpx_mult_axis (default build and a
//           full-precision OUT_BITS=25/SHIFT=0 instance).
// Rev     : 1.0  initial release
// ============================================================================

module tb_cpx_mult_axis;

`ifdef CPX_MULT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, xv, yv, conj, last_in, tready;
  logic [11:0] xi, xq, yi, yq;
  logic        x_rdy, y_rdy, ov, olast;
  logic [15:0] oi, oq;
  logic        x_rdy2, y_rdy2, ov2, olast2;
  logic [24:0] oi2, oq2;
  int          n_tests = 0;
  int          n_fail  = 0;

  typedef struct {
    logic [15:0] i;
    logic [15:0] q;
    logic        last;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  cpx_mult_axis #(.XB(12), .YB(12), .OUT_BITS(16), .SHIFT(8)) dut (
    .clk(clk), .rst(rst),
    .m_axis_x_tvalid(xv), .m_axis_x_tready(x_rdy), .xi(xi), .xq(xq),
    .m_axis_y_tvalid(yv), .m_axis_y_tready(y_rdy), .yi(yi), .yq(yq),
    .conj(conj), .last_in(last_in),
    .s_axis_tvalid(ov), .s_axis_tready(tready), .i(oi), .q(oq),
    .s_axis_tlast(olast)
  );

  cpx_mult_axis #(.XB(12), .YB(12), .OUT_BITS(25), .SHIFT(0)) dut_fp (
    .clk(clk), .rst(rst),
    .m_axis_x_tvalid(xv), .m_axis_x_tready(x_rdy2), .xi(xi), .xq(xq),
    .m_axis_y_tvalid(yv), .m_axis_y_tready(y_rdy2), .yi(yi), .yq(yq),
    .conj(conj), .last_in(last_in),
    .s_axis_tvalid(ov2), .s_axis_tready(tready), .i(oi2), .q(oq2),
    .s_axis_tlast(olast2)
  );

  function automatic longint red(longint v, int sh, int ob, bit sat);
    longint r, lim;
    r   = v;
    if (sh > 0) r = (v + (longint'(1) <<< (sh - 1))) >>> sh;
    lim = longint'(1) <<< (ob - 1);
    if (sat) begin
      if (r > lim - 1) r = lim - 1;
      else if (r < -lim) r = -lim;
    end else begin
      r = (r <<< (64 - ob)) >>> (64 - ob);
    end
    return r;
  endfunction

  function automatic exp_t model(logic [11:0] a, logic [11:0] b, logic [11:0] c,
                                 logic [11:0] d, logic cj, logic lst);
    longint ax = $signed(a);
    longint bx = $signed(b);
    longint cx = $signed(c);
    longint dx = $signed(d);
    longint vi, vq;
    exp_t   e;
    if (!cj) begin
      vi = ax * cx - bx * dx;
      vq = bx * cx + ax * dx;
    end else begin
      vi = ax * cx + bx * dx;
      vq = bx * cx - ax * dx;
    end
    e.i    = 16'(red(vi, 8, 16, SAT));
    e.q    = 16'(red(vq, 8, 16, SAT));
    e.last = lst;
    return e;
  endfunction

  // Presents one beat into an idle pipeline and waits (bounded) for its result.
  task automatic fire_one(input logic [11:0] a, input logic [11:0] b,
                          input logic [11:0] c, input logic [11:0] d,
                          input logic cj, input logic lst, output int lat);
    xi = a; xq = b; yi = c; yq = d; conj = cj; last_in = lst;
    xv = 1'b1; yv = 1'b1; tready = 1'b1;
    @(posedge clk); #1;
    xv = 1'b0; yv = 1'b0; lat = 1;
    while (!ov && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; xv = 1'b1; yv = 1'b1; tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (x_rdy !== 1'b0 || y_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: x_rdy=%b y_rdy=%b required 0 0", x_rdy, y_rdy);
    end
    n_tests++;
    if (ov !== 1'b0 || oi !== 16'd0 || oq !== 16'd0 || olast !== 1'b0 || ov2 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: valid=%b i=%h q=%h last=%b fp_valid=%b required 0 0 0 0 0",
               ov, oi, oq, olast, ov2);
    end
    rst = 1'b0; xv = 1'b0; yv = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (x_rdy !== 1'b1 || y_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_pairing: x_rdy=%b y_rdy=%b required 1 0", x_rdy, y_rdy);
    end
    yv = 1'b0;
  endtask

  task automatic test_exact;
    int lat;
    fire_one(12'd3, 12'd4, 12'd5, 12'd6, 1'b0, 1'b1, lat);
    n_tests++;
    if (lat != 3 || $signed(oi2) != -9 || $signed(oq2) != 38 || olast2 !== 1'b1) begin
      n_fail++;
      $display("FAIL exact_mul: lat=%0d i=%0d q=%0d last=%b required 3 -9 38 1",
               lat, $signed(oi2), $signed(oq2), olast2);
    end
    fire_one(12'd3, 12'd4, 12'd5, 12'd6, 1'b1, 1'b0, lat);
    n_tests++;
    if (lat != 3 || $signed(oi2) != 39 || $signed(oq2) != 2 || olast2 !== 1'b0) begin
      n_fail++;
      $display("FAIL exact_conj: lat=%0d i=%0d q=%0d last=%b required 3 39 2 0",
               lat, $signed(oi2), $signed(oq2), olast2);
    end
  endtask

  task automatic test_round;
    int lat;
    fire_one(12'd16, 12'd0, 12'd24, 12'd0, 1'b0, 1'b0, lat);
    n_tests++;
    if (lat != 3 || oi !== 16'd2 || oq !== 16'd0) begin
      n_fail++;
      $display("FAIL round_pos: lat=%0d i=%0d q=%0d required 3 2 0", lat, $signed(oi), $signed(oq));
    end
    fire_one(12'hFF0, 12'd0, 12'd24, 12'd0, 1'b0, 1'b0, lat);
    n_tests++;
    if (lat != 3 || oi !== 16'hFFFF || oq !== 16'd0) begin
      n_fail++;
      $display("FAIL round_neg: lat=%0d i=%0d q=%0d required 3 -1 0", lat, $signed(oi), $signed(oq));
    end
  endtask

  task automatic test_sat;
    int          lat;
    logic [15:0] req_i;
    req_i = SAT ? 16'h7FFF : 16'h8000;
    // yq=+2048 is not representable in 12 bits; conj of -2048-2048j gives -2048+2048j.
    fire_one(12'h800, 12'h800, 12'h800, 12'h800, 1'b1, 1'b0, lat);
    n_tests++;
    if (lat != 3 || oi !== req_i || oq !== 16'd0) begin
      n_fail++;
      $display("FAIL limit: lat=%0d i=%0d q=%0d required 3 %0d 0",
               lat, $signed(oi), $signed(oq), $signed(req_i));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    int          sent = 0;
    int          cyc  = 0;
    bit          held = 1'b0;
    logic [15:0] hi, hq;
    logic        hl;
    exp_t        e;
    sbq.delete();
    while ((sent < 100 || sbq.size() > 0) && cyc < 5000) begin
      tready  = ($urandom_range(1, 0) == 1);
      xv      = (sent < 100) && ($urandom_range(1, 0) == 1);
      yv      = (sent < 100) && ($urandom_range(1, 0) == 1);
      xi      = 12'($urandom); xq = 12'($urandom);
      yi      = 12'($urandom); yq = 12'($urandom);
      conj    = ($urandom_range(1, 0) == 1);
      last_in = ($urandom_range(1, 0) == 1);
      @(negedge clk);
      if (held) begin
        n_tests++;
        if (ov !== 1'b1 || oi !== hi || oq !== hq || olast !== hl) begin
          n_fail++;
          $display("FAIL stall_hold: valid=%b i=%h q=%h last=%b required 1 %h %h %b",
                   ov, oi, oq, olast, hi, hq, hl);
        end
      end
      n_tests++;
      if ((xv && x_rdy) !== (yv && y_rdy)) begin
        n_fail++;
        $display("FAIL pair_xfer: x_xfer=%b y_xfer=%b required equal", xv && x_rdy, yv && y_rdy);
      end
      if (xv && x_rdy) begin
        sbq.push_back(model(xi, xq, yi, yq, conj, last_in));
        sent++;
      end
      held = 1'b0;
      if (ov) begin
        if (tready) begin
          n_tests++;
          if (sbq.size() == 0) begin
            n_fail++;
            $display("FAIL rand_extra: got i=%h q=%h required no beat", oi, oq);
          end else begin
            e = sbq.pop_front();
            if (oi !== e.i || oq !== e.q || olast !== e.last) begin
              n_fail++;
              $display("FAIL rand_beat: i=%h q=%h last=%b required %h %h %b",
                       oi, oq, olast, e.i, e.q, e.last);
            end
          end
        end else begin
          held = 1'b1; hi = oi; hq = oq; hl = olast;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    n_tests++;
    if (cyc >= 5000) begin
      n_fail++;
      $display("FAIL rand_timeout: sent=%0d pending=%0d required 100 0", sent, sbq.size());
    end
    xv = 1'b0; yv = 1'b0; tready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back_reset;
    int   lat;
    int   stale = 0;
    exp_t e;
    tready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      xi = 12'd100 + 12'(k); xq = 12'd7; yi = 12'd50; yq = 12'hFF3;
      conj = 1'b0; last_in = 1'b1; xv = 1'b1; yv = 1'b1;
      @(negedge clk);
      n_tests++;
      if (!(x_rdy && y_rdy)) begin
        n_fail++;
        $display("FAIL b2b_fire%0d: x_rdy=%b y_rdy=%b required 1 1", k, x_rdy, y_rdy);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1; xv = 1'b0; yv = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (ov !== 1'b0 || ov2 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_rst_valid: valid=%b fp_valid=%b required 0 0", ov, ov2);
    end
    rst = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ov || ov2) stale++;
    end
    n_tests++;
    if (stale != 0) begin
      n_fail++;
      $display("FAIL b2b_stale: stale_cycles=%0d required 0", stale);
    end
    e = model(12'd300, 12'hF00, 12'd77, 12'd500, 1'b1, 1'b1);
    fire_one(12'd300, 12'hF00, 12'd77, 12'd500, 1'b1, 1'b1, lat);
    n_tests++;
    if (lat != 3 || oi !== e.i || oq !== e.q || olast !== e.last) begin
      n_fail++;
      $display("FAIL b2b_after: lat=%0d i=%h q=%h last=%b required 3 %h %h %b",
               lat, oi, oq, olast, e.i, e.q, e.last);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; xv = 1'b0; yv = 1'b0; conj = 1'b0; last_in = 1'b0; tready = 1'b1;
    xi = '0; xq = '0; yi = '0; yq = '0;
    test_reset();
    test_exact();
    test_round();
    test_sat();
    test_random();
    test_back_to_back_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cpx_mult_axis.md
CPX_MULT_AXIS -- requirements
Module: cpx_mult_axis

Interface
REQ-001 SHALL provide parameter XB, default 12, signed bit width of each x component (xi, xq).
REQ-002 SHALL provide parameter YB, default 12, signed bit width of each y component (yi, yq).
REQ-003 SHALL provide parameter OUT_BITS, default 16, signed bit width of each output component.
REQ-004 SHALL provide parameter SHIFT, default 8, arithmetic right shift applied to the full-precision result, range 0..XB+YB.
REQ-005 SHALL provide port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL provide port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL provide ports m_axis_x_tvalid input 1, m_axis_x_tready output 1, xi input XB, xq input XB: x operand beat.
REQ-008 SHALL provide ports m_axis_y_tvalid input 1, m_axis_y_tready output 1, yi input YB, yq input YB: y operand beat.
REQ-009 SHALL provide port conj  input  1  sampled with the y beat; 1 selects x*conj(y).
REQ-010 SHALL provide port last_in  input  1  sampled with the x beat; frame marker carried through.
REQ-011 SHALL provide ports s_axis_tvalid output 1, s_axis_tready input 1, i output OUT_BITS, q output OUT_BITS, s_axis_tlast output 1: result beat.

Function
REQ-012 SHALL define full-precision width P = XB+YB+1; all products and sums computed signed at P bits without loss.
REQ-013 SHALL compute i = xi*yi - xq*yq, q = xq*yi + xi*yq when conj=0; i = xi*yi + xq*yq, q = xq*yi - xi*yq when conj=1.
REQ-014 SHALL accept a beat ("fire") only when m_axis_x_tvalid, m_axis_y_tvalid and adv are all 1, where adv = !s_axis_tvalid_stage3 || s_axis_tready.
REQ-015 SHALL drive m_axis_x_tready = adv & m_axis_y_tvalid and m_axis_y_tready = adv & m_axis_x_tvalid, so x and y always transfer on the same cycle.
REQ-016 SHALL use 3 register stages: S1 four products, S2 add/sub, S3 round/shift/limit; latency fire -> s_axis_tvalid = 3 cycles with s_axis_tready held 1.
REQ-017 SHALL carry a valid bit, conj and last with each stage; bubbles propagate as invalid stages.
REQ-018 SHALL, when adv=0, hold every stage (data, valid, conj, last) unchanged; s_axis_tvalid, i, q, s_axis_tlast stable until accepted.
REQ-019 SHALL sustain 1 beat/cycle with continuous valid and s_axis_tready=1.
REQ-020 SHALL round half-up before shift: r = (v + 2^(SHIFT-1)) >>> SHIFT for SHIFT>0, r = v for SHIFT=0; rounding add performed at P+1 bits.
REQ-021 SHALL reduce r to OUT_BITS per the Configuration section; OUT_BITS >= P-SHIFT+1 passes r unchanged (sign-extended).
REQ-022 SHALL not drop or duplicate beats under any tvalid/tready pattern.

Reset
REQ-023 SHALL, on rst=1 at a clock edge, clear all stage valid bits; s_axis_tvalid=0, i=0, q=0, s_axis_tlast=0 after that edge.
REQ-024 SHALL discard in-flight beats when rst asserts mid-operation; no output produced for them.
REQ-025 SHALL hold m_axis_x_tready and m_axis_y_tready at 0 while rst=1.

Configuration
REQ-026 SHALL, with macro CPX_MULT_SAT_EN defined, saturate r to [-2^(OUT_BITS-1), 2^(OUT_BITS-1)-1] independently per component.
REQ-027 SHALL, without CPX_MULT_SAT_EN, keep the low OUT_BITS bits of r (two's-complement wrap); latency unchanged either way.

Verification (XB=YB=12 unless stated)
REQ-028 SHALL cover: OUT_BITS=25, SHIFT=0, x=3+4j, y=5+6j, conj=0 -> i=-9, q=38, s_axis_tvalid exactly 3 cycles after fire; conj=1 -> i=39, q=2.
REQ-029 SHALL cover: OUT_BITS=16, SHIFT=8, x=16+0j, y=24+0j -> i=2 (384 rounds up); x=-16+0j, y=24+0j -> i=-1.
REQ-030 SHALL cover: OUT_BITS=16, SHIFT=8, x=-2048-2048j, y=-2048+2048j -> i=32767 with CPX_MULT_SAT_EN, i=-32768 without; q=0.
REQ-031 SHALL cover: 100 random beats, s_axis_tready random 50% duty, x/y valid independently random -> output sequence equals golden model, order kept, tlast aligned, outputs stable while stalled.
REQ-032 SHALL cover: 3 beats fired back-to-back, rst high on the cycle after third fire -> s_axis_tvalid=0 next cycle, no stale beats emitted after rst drops, next fired beat emerges with latency 3.
